mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage between EX/MEM register and the combinational write-back stage.
//  Drives the data-memory request/ready/rvalid handshake, builds store masks/data, aligns
//  and sign/zero-extends load data, stalls upstream while an access is outstanding, and
//  registers all retire/trace fields into the MEM/WB register consumed by write-back.
// PARAMETERS
//  TIMEOUT   256  cycles in WAIT_RSP without i_dmem_rvalid before bus-error trap (>=2)
// PORTS
//  i_clk            in   1   clock, all state on rising edge
//  i_rst            in   1   asynchronous reset, active-high
//  i_vld            in   1   instruction in MEM is valid (inputs held stable while o_stall)
//  i_res            in   32  ALU result; effective address for loads/stores
//  i_funct3         in   3   access size/sign: 000 B,001 H,010 W,100 BU,101 HU
//  i_mem_ren/i_mem_wen in 1  load / store
//  i_mem_reg        in   1   result comes from memory (forwarded to WB)
//  i_rs2_rdata      in   32  store data; i_rs1_raddr/i_rs2_raddr/i_rs1_rdata pass-through
//  i_rd_waddr/i_rd_wen in 5/1  destination; i_inst/i_pc/i_nxt_pc in 32 pass-through
//  o_dmem_req       out  1   request valid; o_dmem_addr out 32 word-aligned address
//  o_dmem_we        out  1   write request; o_dmem_be out 4 byte enables; o_dmem_wdata out 32
//  i_dmem_ready     in   1   request accepted this cycle
//  i_dmem_rvalid    in   1   read response valid; i_dmem_rdata in 32 raw word
//  o_stall          out  1   hold EX/MEM register and earlier stages
//  o_vld,o_trap     out  1   MEM/WB valid; access fault (misaligned or timeout)
//  o_res,o_mem_reg  out  32/1 ALU result, select for WB
//  o_dmem_rdata     out  32  aligned/extended load data; o_dmem_rdata_raw out 32 raw word
//  o_* trace        out  -   registered copies: rd_waddr,rd_wen,inst,rs1/rs2 addr+data,
//                            dmem_addr(byte addr),dmem_mask,dmem_ren,dmem_wen,dmem_wdata,pc,nxt_pc
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0, every registered output 0, o_dmem_req 0.
//  - mem_op = i_vld & (ren|wen) & !misalign. misalign: H/HU with addr[0]; W with addr[1:0]!=0.
//  - FSM IDLE: mem_op -> o_dmem_req=1 (comb). ready&wen -> done; ready&ren -> WAIT_RSP;
//    !ready -> REQ. REQ: hold req/addr/be/wdata stable until ready, same exits as IDLE.
//    WAIT_RSP: req=0; rvalid -> done, IDLE; count==TIMEOUT-1 -> done with o_trap, IDLE.
//  - rvalid is legal no earlier than the cycle after acceptance; rvalid in IDLE/REQ ignored.
//  - o_stall = mem_op & !done. MEM/WB register loads when !o_stall; o_vld<=i_vld&!o_stall,
//    so a stalled cycle inserts a bubble (o_vld=0, other fields don't-care but held).
//  - Latency: non-memory op and store with ready in IDLE: 1 cycle to o_vld. Load: o_vld
//    the cycle after rvalid. Misaligned: no request, 1 cycle, o_vld=1,o_trap=1,o_rd_wen=0.
//  - Store: SB be=0001<<a[1:0], wdata={4{b}}; SH be=0011<<{a[1],0}, wdata={2{h}}; SW 1111.
//  - Load: lane select by a[1:0]; B/H sign-extend, BU/HU zero-extend, W as-is. o_dmem_mask
//    records the be used (loads too); o_dmem_rdata_raw = unmodified i_dmem_rdata.
//  - Timeout counter: clears on entry to WAIT_RSP, increments each WAIT_RSP cycle.
//  - Timeout trap: o_rd_wen=0, o_dmem_rdata=0. Late rvalid after timeout ignored.
//  - Async reset mid-access: FSM to IDLE at once, o_dmem_req drops, pending rvalid dropped.
//  - i_vld=0 with ren/wen set: no request, no stall.
// STRUCTURE
//  - Shared package: funct3 size codes (F3_B,F3_H,F3_W,F3_BU,F3_HU), FSM state encoding
//    (IDLE,REQ,WAIT_RSP), byte-enable constants.
//  - Sub-module mem_align (combinational): store be/wdata generation, load extract/extend,
//    misalign detect; mem_stage holds FSM, timeout counter, MEM/WB register.
// TESTING
//  - ADD res=0x1234, rd=5: o_vld=1 next cycle, o_res=0x1234, o_stall never high.
//  - SB addr 0x103 data 0xAB, ready=1: be=1000, wdata=0xABABABAB, addr=0x100, no stall.
//  - LB addr 0x102, ready after 2 cycles, rvalid 3 later data 0x0080_0000: o_stall 5 cycles,
//    o_dmem_rdata=0xFFFFFF80; LBU same -> 0x00000080; o_dmem_rdata_raw=0x00800000.
//  - LW addr 0x101: no o_dmem_req, o_vld=1, o_trap=1, o_rd_wen=0 one cycle later.
//  - LW, rvalid withheld: o_trap=1 after TIMEOUT cycles in WAIT_RSP; late rvalid ignored.
//  - i_rst pulsed in WAIT_RSP: o_dmem_req=0, o_vld=0 at once; next op completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access size codes, FSM states
// and byte-enable base patterns.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational data-path helper: store byte enables and lane replication,
// load lane extraction with sign/zero extension, and misalignment detection.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Halfword lanes are picked by addr[1] only; addr[0] set is a misaligned access.
  assign lane_b = 8'(ld_word >> {addr_lo, 3'b000});
  assign lane_h = 16'(ld_word >> {addr_lo[1], 4'b0000});

  always_comb begin
    be       = BE_WORD;
    st_wdata = st_data;
    ld_data  = ld_word;
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be       = BE_BYTE << addr_lo;
        st_wdata = {4{st_data[7:0]}};
        ld_data  = (funct3 == F3_B) ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      end
      F3_H, F3_HU: begin
        be       = BE_HALF << {addr_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
        ld_data  = (funct3 == F3_H) ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
        misalign = addr_lo[0];
      end
      F3_W: begin
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory handshake FSM with response timeout,
// upstream stall generation and the MEM/WB register with retire/trace fields.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic [31:0] i_res,
  input  logic [2:0]  i_funct3,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic        i_mem_reg,
  input  logic [4:0]  i_rs1_raddr,
  input  logic [4:0]  i_rs2_raddr,
  input  logic [31:0] i_rs1_rdata,
  input  logic [31:0] i_rs2_rdata,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  output logic        o_dmem_req,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_we,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_vld,
  output logic        o_trap,
  output logic [31:0] o_res,
  output logic        o_mem_reg,
  output logic [31:0] o_dmem_rdata,
  output logic [31:0] o_dmem_rdata_raw,
  output logic [4:0]  o_rd_waddr,
  output logic        o_rd_wen,
  output logic [31:0] o_inst,
  output logic [4:0]  o_rs1_raddr,
  output logic [4:0]  o_rs2_raddr,
  output logic [31:0] o_rs1_rdata,
  output logic [31:0] o_rs2_rdata,
  output logic [31:0] o_trc_dmem_addr,
  output logic [3:0]  o_trc_dmem_mask,
  output logic        o_trc_dmem_ren,
  output logic        o_trc_dmem_wen,
  output logic [31:0] o_trc_dmem_wdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  mem_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;
  logic             misalign;
  logic             mem_op;
  logic             req;
  logic             done;
  logic             rsp_ok;
  logic             timeout_hit;
  logic             stall;
  logic             trap;

  mem_align u_align (
    .addr_lo  (i_res[1:0]),
    .funct3   (i_funct3),
    .st_data  (i_rs2_rdata),
    .ld_word  (i_dmem_rdata),
    .be       (be),
    .st_wdata (st_wdata),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  assign mem_op = i_vld & (i_mem_ren | i_mem_wen) & ~misalign;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stores finish on acceptance; loads wait for rvalid or give up at the timeout.
  always_comb begin
    state_nxt   = state;
    req         = 1'b0;
    done        = 1'b0;
    rsp_ok      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE, REQ: begin
        state_nxt = IDLE;
        if (mem_op) begin
          req = 1'b1;
          if (!i_dmem_ready)   state_nxt = REQ;
          else if (i_mem_wen)  done      = 1'b1;
          else                 state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (i_dmem_rvalid) begin
          done      = 1'b1;
          rsp_ok    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          done        = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                          cnt <= '0;
    else if (state != WAIT_RSP && state_nxt == WAIT_RSP) cnt <= '0;
    else if (state == WAIT_RSP)                         cnt <= cnt + CNT_W'(1);
  end

  assign stall        = mem_op & ~done;
  assign o_stall      = stall & ~i_rst;
  assign o_dmem_req   = req & ~i_rst;
  assign o_dmem_addr  = {i_res[31:2], 2'b00};
  assign o_dmem_we    = i_mem_wen;
  assign o_dmem_be    = be;
  assign o_dmem_wdata = st_wdata;

  assign trap = (i_vld & (i_mem_ren | i_mem_wen) & misalign) | timeout_hit;

  // A stalled cycle retires a bubble while the payload fields keep their last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld            <= 1'b0;
      o_trap           <= 1'b0;
      o_res            <= '0;
      o_mem_reg        <= 1'b0;
      o_dmem_rdata     <= '0;
      o_dmem_rdata_raw <= '0;
      o_rd_waddr       <= '0;
      o_rd_wen         <= 1'b0;
      o_inst           <= '0;
      o_rs1_raddr      <= '0;
      o_rs2_raddr      <= '0;
      o_rs1_rdata      <= '0;
      o_rs2_rdata      <= '0;
      o_trc_dmem_addr  <= '0;
      o_trc_dmem_mask  <= '0;
      o_trc_dmem_ren   <= 1'b0;
      o_trc_dmem_wen   <= 1'b0;
      o_trc_dmem_wdata <= '0;
      o_pc             <= '0;
      o_nxt_pc         <= '0;
    end else begin
      o_vld <= i_vld & ~stall;
      if (!stall) begin
        o_trap           <= trap;
        o_res            <= i_res;
        o_mem_reg        <= i_mem_reg;
        o_dmem_rdata     <= rsp_ok ? ld_data : '0;
        o_dmem_rdata_raw <= rsp_ok ? i_dmem_rdata : '0;
        o_rd_waddr       <= i_rd_waddr;
        o_rd_wen         <= i_rd_wen & ~trap;
        o_inst           <= i_inst;
        o_rs1_raddr      <= i_rs1_raddr;
        o_rs2_raddr      <= i_rs2_raddr;
        o_rs1_rdata      <= i_rs1_rdata;
        o_rs2_rdata      <= i_rs2_rdata;
        o_trc_dmem_addr  <= i_res;
        o_trc_dmem_mask  <= be;
        o_trc_dmem_ren   <= i_mem_ren;
        o_trc_dmem_wen   <= i_mem_wen;
        o_trc_dmem_wdata <= st_wdata;
        o_pc             <= i_pc;
        o_nxt_pc         <= i_nxt_pc;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed accesses against a transaction-level
// model, checked every cycle, plus hand-computed literal expectations.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 16;

  logic        i_clk, i_rst, i_vld;
  logic [31:0] i_res;
  logic [2:0]  i_funct3;
  logic        i_mem_ren, i_mem_wen, i_mem_reg;
  logic [4:0]  i_rs1_raddr, i_rs2_raddr, i_rd_waddr;
  logic [31:0] i_rs1_rdata, i_rs2_rdata, i_inst, i_pc, i_nxt_pc;
  logic        i_rd_wen;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ready, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_stall, o_vld, o_trap, o_mem_reg, o_rd_wen;
  logic [31:0] o_res, o_dmem_rdata, o_dmem_rdata_raw, o_inst, o_rs1_rdata, o_rs2_rdata;
  logic [4:0]  o_rd_waddr, o_rs1_raddr, o_rs2_raddr;
  logic [31:0] o_trc_dmem_addr, o_trc_dmem_wdata, o_pc, o_nxt_pc;
  logic [3:0]  o_trc_dmem_mask;
  logic        o_trc_dmem_ren, o_trc_dmem_wen;

  mem_stage #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_res(i_res), .i_funct3(i_funct3),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_reg(i_mem_reg),
    .i_rs1_raddr(i_rs1_raddr), .i_rs2_raddr(i_rs2_raddr), .i_rs1_rdata(i_rs1_rdata),
    .i_rs2_rdata(i_rs2_rdata), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen),
    .i_inst(i_inst), .i_pc(i_pc), .i_nxt_pc(i_nxt_pc),
    .o_dmem_req(o_dmem_req), .o_dmem_addr(o_dmem_addr), .o_dmem_we(o_dmem_we),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_vld(o_vld), .o_trap(o_trap), .o_res(o_res), .o_mem_reg(o_mem_reg),
    .o_dmem_rdata(o_dmem_rdata), .o_dmem_rdata_raw(o_dmem_rdata_raw),
    .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen), .o_inst(o_inst),
    .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
    .o_rs1_rdata(o_rs1_rdata), .o_rs2_rdata(o_rs2_rdata),
    .o_trc_dmem_addr(o_trc_dmem_addr), .o_trc_dmem_mask(o_trc_dmem_mask),
    .o_trc_dmem_ren(o_trc_dmem_ren), .o_trc_dmem_wen(o_trc_dmem_wen),
    .o_trc_dmem_wdata(o_trc_dmem_wdata), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc)
  );

  typedef struct {
    int          due;
    logic        trap;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mem_reg;
    logic        chk_mask;
    logic [3:0]  mask;
    logic        chk_wd;
    logic [31:0] wd;
    logic        chk_ld;
    logic [31:0] rdata;
    logic        chk_raw;
    logic [31:0] raw;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_seen = 0;
  bit          in_reset;
  logic        exp_req, exp_stall, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference model: access rules written as plain arithmetic on byte offsets.
  function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
    if ((f3 == F3_H || f3 == F3_HU) && (a % 2) != 0) return 1'b1;
    if (f3 == F3_W && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (f3 == F3_B || f3 == F3_BU) return 4'(1 << off);
    if (f3 == F3_H || f3 == F3_HU) return 4'(3 << (off & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == F3_B || f3 == F3_BU) return {24'b0, d[7:0]} * 32'h01010101;
    if (f3 == F3_H || f3 == F3_HU) return {16'b0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    int x;
    v = w >> (8 * (a % 4));
    case (f3)
      F3_B:  begin x = int'(v & 32'hFF);   if (x >= 128)   x -= 256;   return 32'(x); end
      F3_BU: return v & 32'hFF;
      F3_H:  begin x = int'(v & 32'hFFFF); if (x >= 32768) x -= 65536; return 32'(x); end
      F3_HU: return v & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
    end
  endtask

  // Per-cycle comparison of handshake, stall and retire outputs against the model.
  always @(negedge i_clk) begin
    if (in_reset) begin
      check_output("rst_vld", 32'(o_vld), 32'd0);
      check_output("rst_req", 32'(o_dmem_req), 32'd0);
    end else begin
      check_output("req", 32'(o_dmem_req), 32'(exp_req));
      check_output("stall", 32'(o_stall), 32'(exp_stall));
      if (o_stall) stall_seen++;
      if (exp_req) begin
        check_output("req_addr", o_dmem_addr, exp_addr);
        check_output("req_be", 32'(o_dmem_be), 32'(exp_be));
        check_output("req_we", 32'(o_dmem_we), 32'(exp_we));
        if (exp_we) check_output("req_wdata", o_dmem_wdata, exp_wdata);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        cur = q.pop_front();
        check_output("vld", 32'(o_vld), 32'd1);
        check_output("trap", 32'(o_trap), 32'(cur.trap));
        check_output("res", o_res, cur.res);
        check_output("rd_waddr", 32'(o_rd_waddr), 32'(cur.rd));
        check_output("rd_wen", 32'(o_rd_wen), 32'(cur.rd_wen));
        check_output("pc", o_pc, cur.pc);
        check_output("nxt_pc", o_nxt_pc, cur.pc + 32'd4);
        check_output("inst", o_inst, cur.inst);
        check_output("mem_reg", 32'(o_mem_reg), 32'(cur.mem_reg));
        if (cur.chk_mask) begin
          check_output("mask", 32'(o_trc_dmem_mask), 32'(cur.mask));
          check_output("trc_addr", o_trc_dmem_addr, cur.res);
        end
        if (cur.chk_wd)  check_output("trc_wdata", o_trc_dmem_wdata, cur.wd);
        if (cur.chk_ld)  check_output("ld_rdata", o_dmem_rdata, cur.rdata);
        if (cur.chk_raw) check_output("ld_raw", o_dmem_rdata_raw, cur.raw);
      end else begin
        check_output("vld_idle", 32'(o_vld), 32'd0);
      end
    end
  end

  // Drives one instruction; ready after rdy_dly cycles, rvalid rv_dly cycles after acceptance (-1: never).
  task automatic apply_stimulus(input logic vld, input logic [2:0] f3, input logic ren,
                                input logic wen, input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                                input logic [4:0] rd, input logic [31:0] pc);
    exp_t e;
    logic mis, memop;
    mis   = m_misal(f3, addr);
    memop = vld && (ren || wen) && !mis;
    i_vld = vld; i_funct3 = f3; i_mem_ren = ren; i_mem_wen = wen; i_mem_reg = ren;
    i_res = addr; i_rs2_rdata = sdata; i_rs1_rdata = ~sdata;
    i_rs1_raddr = rd + 5'd1; i_rs2_raddr = rd + 5'd2; i_rd_waddr = rd; i_rd_wen = 1'b1;
    i_inst = pc ^ 32'h13; i_pc = pc; i_nxt_pc = pc + 32'd4;
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = rdata;
    e.due = 0; e.trap = vld && (ren || wen) && mis; e.res = addr; e.rd = rd;
    e.rd_wen = !e.trap; e.pc = pc; e.inst = pc ^ 32'h13; e.mem_reg = ren;
    e.chk_mask = memop; e.mask = m_be(f3, addr);
    e.chk_wd = memop && wen; e.wd = m_wdata(f3, sdata);
    e.chk_ld = memop && ren && !wen; e.rdata = 32'd0; e.chk_raw = 1'b0; e.raw = rdata;
    exp_be = m_be(f3, addr); exp_addr = addr & ~32'd3; exp_we = wen; exp_wdata = m_wdata(f3, sdata);
    if (!memop) begin
      exp_req = 1'b0; exp_stall = 1'b0;
      if (vld) begin e.due = cyc + 1; q.push_back(e); end
      @(posedge i_clk); #1;
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        exp_req = 1'b1;
        i_dmem_ready = (k == rdy_dly);
        exp_stall = !(wen && k == rdy_dly);
        if (wen && k == rdy_dly) begin e.due = cyc + 1; q.push_back(e); end
        @(posedge i_clk); #1;
      end
      i_dmem_ready = 1'b0;
      if (!wen) begin
        for (int j = 1; j <= TO; j++) begin
          exp_req = 1'b0;
          i_dmem_rvalid = (j == rv_dly);
          if (j == rv_dly) begin
            exp_stall = 1'b0; e.rdata = m_load(f3, addr, rdata); e.chk_raw = 1'b1;
            e.due = cyc + 1; q.push_back(e);
          end else if (j == TO) begin
            exp_stall = 1'b0; e.trap = 1'b1; e.rd_wen = 1'b0; e.rdata = 32'd0;
            e.due = cyc + 1; q.push_back(e);
          end else begin
            exp_stall = 1'b1;
          end
          @(posedge i_clk); #1;
          if (j == rv_dly) break;
        end
        i_dmem_rvalid = 1'b0;
      end
    end
  endtask

  initial begin
    in_reset = 1'b1; i_rst = 1'b1;
    exp_req = 1'b0; exp_stall = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    i_vld = 0; i_res = 0; i_funct3 = 0; i_mem_ren = 0; i_mem_wen = 0; i_mem_reg = 0;
    i_rs1_raddr = 0; i_rs2_raddr = 0; i_rs1_rdata = 0; i_rs2_rdata = 0; i_rd_waddr = 0;
    i_rd_wen = 0; i_inst = 0; i_pc = 0; i_nxt_pc = 0;
    i_dmem_ready = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check_output("reset_vld", 32'(o_vld), 32'd0);
    check_output("reset_trap", 32'(o_trap), 32'd0);
    check_output("reset_res", o_res, 32'd0);
    check_output("reset_rd_wen", 32'(o_rd_wen), 32'd0);
    check_output("reset_mask", 32'(o_trc_dmem_mask), 32'd0);
    i_rst = 1'b0; in_reset = 1'b0;
    apply_stimulus(0, F3_W, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ALU op passes straight through
    stall_seen = 0;
    apply_stimulus(1, F3_W, 0, 0, 32'h1234, 0, 0, 0, 0, 5'd5, 32'h1000);
    check_output("add_res", o_res, 32'h1234);
    check_output("add_rd", 32'(o_rd_waddr), 32'd5);
    check_output("add_stall", 32'(stall_seen), 32'd0);

    // Byte store accepted at once
    stall_seen = 0;
    apply_stimulus(1, F3_B, 0, 1, 32'h103, 32'h000000AB, 0, 0, 0, 5'd0, 32'h1004);
    check_output("sb_mask", 32'(o_trc_dmem_mask), 32'h8);
    check_output("sb_wdata", o_trc_dmem_wdata, 32'hABABABAB);
    check_output("sb_stall", 32'(stall_seen), 32'd0);

    apply_stimulus(1, F3_H, 0, 1, 32'h102, 32'h1234BEEF, 0, 1, 0, 5'd0, 32'h1008);
    check_output("sh_mask", 32'(o_trc_dmem_mask), 32'hC);
    apply_stimulus(1, F3_W, 0, 1, 32'h200, 32'hDEADBEEF, 0, 0, 0, 5'd0, 32'h100C);

    // Signed and unsigned byte loads with a delayed ready and response
    stall_seen = 0;
    apply_stimulus(1, F3_B, 1, 0, 32'h102, 0, 32'h00800000, 2, 3, 5'd7, 32'h1010);
    check_output("lb_rdata", o_dmem_rdata, 32'hFFFFFF80);
    check_output("lb_stall_cycles", 32'(stall_seen), 32'd5);
    apply_stimulus(1, F3_BU, 1, 0, 32'h102, 0, 32'h00800000, 2, 3, 5'd8, 32'h1014);
    check_output("lbu_rdata", o_dmem_rdata, 32'h00000080);
    check_output("lbu_raw", o_dmem_rdata_raw, 32'h00800000);
    apply_stimulus(1, F3_H, 1, 0, 32'h102, 0, 32'h80010000, 0, 1, 5'd9, 32'h1018);
    check_output("lh_rdata", o_dmem_rdata, 32'hFFFF8001);
    apply_stimulus(1, F3_HU, 1, 0, 32'h100, 0, 32'h1234F00D, 1, 2, 5'd10, 32'h101C);
    check_output("lhu_rdata", o_dmem_rdata, 32'h0000F00D);
    apply_stimulus(1, F3_W, 1, 0, 32'h104, 0, 32'hCAFEBABE, 0, 1, 5'd11, 32'h1020);

    // Misaligned accesses trap without touching the bus
    apply_stimulus(1, F3_W, 1, 0, 32'h101, 0, 0, 0, 0, 5'd12, 32'h1024);
    check_output("misal_vld", 32'(o_vld), 32'd1);
    check_output("misal_trap", 32'(o_trap), 32'd1);
    check_output("misal_rd_wen", 32'(o_rd_wen), 32'd0);
    apply_stimulus(1, F3_H, 0, 1, 32'h101, 32'h5555, 0, 0, 0, 5'd0, 32'h1028);

    // Invalid slot with ren/wen set: no request, no stall
    apply_stimulus(0, F3_W, 1, 1, 32'h400, 0, 0, 0, 0, 5'd13, 32'h102C);

    // Withheld response times out; a late rvalid afterwards is ignored
    stall_seen = 0;
    apply_stimulus(1, F3_W, 1, 0, 32'h500, 0, 32'h11111111, 0, -1, 5'd14, 32'h1030);
    check_output("to_trap", 32'(o_trap), 32'd1);
    check_output("to_rdata", o_dmem_rdata, 32'd0);
    check_output("to_stall_cycles", 32'(stall_seen), 32'(TO));
    i_vld = 1'b0; exp_req = 1'b0; exp_stall = 1'b0; i_dmem_rvalid = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1'b0;
    apply_stimulus(1, F3_W, 1, 0, 32'h504, 0, 32'h22222222, 0, 2, 5'd15, 32'h1034);

    // Asynchronous reset while waiting for a response
    i_vld = 1'b1; i_funct3 = F3_W; i_mem_ren = 1'b1; i_mem_wen = 1'b0; i_res = 32'h300;
    i_dmem_ready = 1'b1;
    exp_req = 1'b1; exp_stall = 1'b1; exp_be = 4'hF; exp_addr = 32'h300; exp_we = 1'b0;
    @(posedge i_clk); #1;
    i_dmem_ready = 1'b0; exp_req = 1'b0; exp_stall = 1'b1;
    @(posedge i_clk); #1;
    in_reset = 1'b1; i_rst = 1'b1;
    #1;
    check_output("midrst_req", 32'(o_dmem_req), 32'd0);
    check_output("midrst_vld", 32'(o_vld), 32'd0);
    i_vld = 1'b0; i_mem_ren = 1'b0; i_dmem_rvalid = 1'b1; exp_stall = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0; in_reset = 1'b0;
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1'b0;
    apply_stimulus(1, F3_B, 1, 0, 32'h301, 0, 32'h00007F00, 0, 1, 5'd16, 32'h1038);
    check_output("postrst_rdata", o_dmem_rdata, 32'h0000007F);

    repeat (3) apply_stimulus(0, F3_W, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
